// File: rtl/stopwatch_pkg.sv
// Shared types and timing constants for the stopwatch control slice.
// The default debounce length is derived from the board clock and the debounce window.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      DONE    = 2'd3
   } sw_state_t;

   localparam int CLK_HZ                  = 50_000_000;
   localparam int DEBOUNCE_MS             = 10;
   localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage : stopwatch_pkg

// File: rtl/key_debounce.sv
// One push-button input: 2-flop synchronizer, stability counter and a one-cycle press pulse
// on each accepted debounced 1->0 transition. The key is active-low, so release level is 1.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = stopwatch_pkg::DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic i_key_n,
   output logic o_press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   logic w_differ;
   logic w_accept;

   assign w_differ = (r_sync2 != r_level);
   assign w_accept = w_differ && (r_cnt == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; r_sync2 must see the old r_sync1, not the new one.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_level <= 1'b1;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (!w_differ) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            // Level change accepted; only the falling (pressed) direction is an event.
            r_cnt   <= '0;
            r_level <= r_sync2;
            r_press <= ~r_sync2;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_press = r_press;

endmodule : key_debounce

// File: rtl/stopwatch_ctrl.sv
// Debounced start/stop and clear buttons driving the stopwatch run enable and clear pulse.
// STOPWATCH_CTRL_AUTOSTART_EN: when defined, a clear press restarts timing instead of idling.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_startstop_n,
   input  logic       key_clear_n,
   input  logic       game_done,
   output logic       run,
   output logic       sw_reset,
   output logic [1:0] state
);

`ifdef STOPWATCH_CTRL_AUTOSTART_EN
   localparam sw_state_t CLEAR_TARGET = RUNNING;
`else
   localparam sw_state_t CLEAR_TARGET = IDLE;
`endif

   logic      w_ss_press;
   logic      w_clear_press;
   sw_state_t w_next;

   sw_state_t r_state;
   logic      r_run;
   logic      r_sw_reset;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_key_startstop (
      .clk    (clk),
      .reset  (reset),
      .i_key_n(key_startstop_n),
      .o_press(w_ss_press)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_key_clear (
      .clk    (clk),
      .reset  (reset),
      .i_key_n(key_clear_n),
      .o_press(w_clear_press)
   );

   // Priority: clear, then game_done, then start/stop.
   // NOTE: w_next gets a default before any branch so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      w_next = r_state;
      if (w_clear_press) begin
         w_next = CLEAR_TARGET;
      end else begin
         unique case (r_state)
            IDLE:    if (w_ss_press) w_next = RUNNING;
            RUNNING: begin
               if (game_done)       w_next = DONE;
               else if (w_ss_press) w_next = PAUSED;
            end
            PAUSED:  begin
               if (game_done)       w_next = DONE;
               else if (w_ss_press) w_next = RUNNING;
            end
            DONE:    w_next = DONE;
            default: w_next = IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so nothing reaches the pins combinationally.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_run      <= 1'b0;
         r_sw_reset <= 1'b1;
      end else begin
         r_state    <= w_next;
         r_run      <= (w_next == RUNNING);
         r_sw_reset <= w_clear_press;
      end
   end

   assign run      = r_run;
   assign sw_reset = r_sw_reset;
   assign state    = r_state;

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// Directed plus randomized bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, compared every cycle
// against a reference model that accepts a key level once the last 4 synchronized samples agree.
module tb_stopwatch_ctrl;

   localparam int D = 4;
`ifdef STOPWATCH_CTRL_AUTOSTART_EN
   localparam int CLR_TGT = 1;
`else
   localparam int CLR_TGT = 0;
`endif

   logic       clk;
   logic       reset;
   logic       key_startstop_n;
   logic       key_clear_n;
   logic       game_done;
   logic       run;
   logic       sw_reset;
   logic [1:0] state;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: index 0 = start/stop key, 1 = clear key.
   int m_state;
   bit m_run;
   bit m_sw;
   bit raw_h [2][2];
   bit seen_h[2][D];
   bit m_lvl [2];
   bit m_pr  [2];

   stopwatch_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .key_startstop_n(key_startstop_n),
      .key_clear_n    (key_clear_n),
      .game_done      (game_done),
      .run            (run),
      .sw_reset       (sw_reset),
      .state          (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset_keys();
      for (int k = 0; k < 2; k++) begin
         raw_h[k][0] = 1'b1;
         raw_h[k][1] = 1'b1;
         for (int i = 0; i < D; i++) seen_h[k][i] = 1'b1;
         m_lvl[k] = 1'b1;
         m_pr[k]  = 1'b0;
      end
   endtask

   // A key level is accepted once the synchronized value (raw from two edges ago)
   // has disagreed with the current debounced level for D consecutive edges.
   task automatic deb_edge(input int k, input bit raw);
      bit used;
      bit all_diff;
      used        = raw_h[k][1];
      raw_h[k][1] = raw_h[k][0];
      raw_h[k][0] = raw;
      for (int i = D - 1; i > 0; i--) seen_h[k][i] = seen_h[k][i-1];
      seen_h[k][0] = used;
      all_diff = 1'b1;
      for (int i = 0; i < D; i++) if (seen_h[k][i] == m_lvl[k]) all_diff = 1'b0;
      m_pr[k] = 1'b0;
      if (all_diff) begin
         m_lvl[k] = ~m_lvl[k];
         m_pr[k]  = (m_lvl[k] == 1'b0);
      end
   endtask

   task automatic model_edge();
      int nxt;
      if (reset) begin
         m_state = 0;
         m_run   = 1'b0;
         m_sw    = 1'b1;
         model_reset_keys();
      end else begin
         nxt = m_state;
         if (m_pr[1])                                       nxt = CLR_TGT;
         else if ((m_state == 1 || m_state == 2) && game_done) nxt = 3;
         else if (m_pr[0] && m_state != 3)                  nxt = (m_state == 1) ? 2 : 1;
         m_sw    = m_pr[1];
         m_state = nxt;
         m_run   = (nxt == 1);
         deb_edge(0, key_startstop_n);
         deb_edge(1, key_clear_n);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         #1;
         check("state", 32'(state), 32'(m_state));
         check("run", 32'(run), 32'(m_run));
         check("sw_reset", 32'(sw_reset), 32'(m_sw));
      end
   endtask

   // Steps n cycles, returning how many of them showed sw_reset high.
   task automatic count_pulses(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         step(1);
         if (sw_reset === 1'b1) begin
            pulses++;
            check("run_at_clear_pulse", 32'(run), 32'(CLR_TGT == 1));
         end
      end
   endtask

   initial begin
      int pulses;
      reset           = 1'b1;
      key_startstop_n = 1'b1;
      key_clear_n     = 1'b1;
      game_done       = 1'b0;
      m_state = 0;
      m_run   = 1'b0;
      m_sw    = 1'b1;
      model_reset_keys();

      // Reset state.
      step(3);
      check("rst_sw_reset", 32'(sw_reset), 1);
      check("rst_state", 32'(state), 0);
      check("rst_run", 32'(run), 0);

      // Start/stop held from the first cycle after reset: accepted after 2+D, state at 3+D.
      reset           = 1'b0;
      key_startstop_n = 1'b0;
      step(1);
      check("rst_release_sw", 32'(sw_reset), 0);
      step(5);
      check("latency_pre", 32'(state), 0);
      step(1);
      check("latency_state", 32'(state), 1);
      check("latency_run", 32'(run), 1);
      step(100);
      check("held_key_run", 32'(run), 1);

      // Short glitch rejected, long press pauses, next press resumes.
      key_startstop_n = 1'b1; step(10);
      key_startstop_n = 1'b0; step(3);
      key_startstop_n = 1'b1; step(10);
      check("glitch_state", 32'(state), 1);
      key_startstop_n = 1'b0; step(10);
      check("pause_state", 32'(state), 2);
      check("pause_run", 32'(run), 0);
      key_startstop_n = 1'b1; step(10);
      key_startstop_n = 1'b0; step(10);
      check("resume_state", 32'(state), 1);
      key_startstop_n = 1'b1; step(10);

      // game_done freezes; start/stop ignored in DONE; clear leaves it with one pulse.
      game_done = 1'b1;
      step(1);
      check("done_state", 32'(state), 3);
      check("done_run", 32'(run), 0);
      key_startstop_n = 1'b0; step(10);
      key_startstop_n = 1'b1; step(10);
      check("done_hold", 32'(state), 3);
      game_done   = 1'b0;
      key_clear_n = 1'b0;
      count_pulses(20, pulses);
      check("clear_pulses", 32'(pulses), 1);
      check("clear_state", 32'(state), 32'(CLR_TGT));
      key_clear_n = 1'b1; step(10);

      // Steer into PAUSED, then press both keys on the same cycle.
      for (int t = 0; t < 4; t++) begin
         if (m_state != 2) begin
            key_startstop_n = 1'b0; step(10);
            key_startstop_n = 1'b1; step(10);
         end
      end
      check("pre_both_state", 32'(state), 2);
      key_startstop_n = 1'b0;
      key_clear_n     = 1'b0;
      count_pulses(20, pulses);
      check("both_pulses", 32'(pulses), 1);
      check("both_state", 32'(state), 32'(CLR_TGT));
      key_startstop_n = 1'b1;
      key_clear_n     = 1'b1;
      step(10);

      // Reset while a start/stop debounce is three counts in; the press must restart from scratch.
      key_startstop_n = 1'b0;
      step(5);
      reset = 1'b1;
      step(1);
      check("mid_rst_sw_reset", 32'(sw_reset), 1);
      check("mid_rst_state", 32'(state), 0);
      reset = 1'b0;
      step(6);
      check("mid_rst_pre", 32'(state), 0);
      step(1);
      check("mid_rst_accept", 32'(state), 1);
      key_startstop_n = 1'b1;
      step(10);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0)  key_startstop_n = ~key_startstop_n;
         if ($urandom_range(0, 9) == 0)  key_clear_n     = ~key_clear_n;
         if ($urandom_range(0, 15) == 0) game_done       = ~game_done;
         reset = ($urandom_range(0, 99) == 0);
         step(1);
      end
      reset = 1'b0;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_stopwatch_ctrl
